lcd_bus_writer: RTL and testbench

- Downstream output stage of the image generator. Sits between the pixel/command sequencer and the 8080-style parallel LCD pins (dcx, wr, D[7:0]).
- Accepts {dcx, byte} items over a valid/ready handshake into a small FIFO.
- Replays each item on the bus with a programmable WR low/high strobe, so upstream logic can issue bytes in bursts without tracking bus timing.

---
 rtl/lcd_bus_writer.sv | 153 +++++++++++++++
 tb/tb_lcd_bus_writer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_writer.sv
// rtl/lcd_bus_writer.sv - 8080-style LCD byte writer with a small input FIFO
//
// Takes {dcx, byte} items over a valid/ready handshake, queues them, and
// replays each on the LCD pins as SETUP (1 cycle, wr high), WR_LOW
// (WR_LOW_CYC cycles, wr low) and WR_HIGH (WR_HIGH_CYC cycles, wr high, hold).
//
// Ports:
//   hwclk       system clock
//   reset       synchronous, active-high reset
//   in_valid    upstream offers an item
//   in_dcx      0 = command byte, 1 = data/parameter byte
//   in_byte     byte to write
//   in_ready    item accepted at an edge where in_valid && in_ready
//   busy        FIFO non-empty or transfer in progress
//   done_pulse  one-cycle pulse per completed byte
//   dcx         LCD D/CX pin (registered)
//   wr          LCD WRX pin, active-low strobe (registered)
//   D           LCD data bus (registered)

module lcd_bus_writer #(
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       hwclk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_dcx,
  input  logic [7:0] in_byte,
  output logic       in_ready,
  output logic       busy,
  output logic       done_pulse,
  output logic       dcx,
  output logic       wr,
  output logic [7:0] D
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int PH_MAX = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
  localparam int PW     = $clog2(PH_MAX) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, WR_LOW, WR_HIGH} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] phase, phase_nxt;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [8:0]    head;

  logic          push, pop;
  logic          wr_nxt, dcx_nxt, done_nxt;
  logic [7:0]    d_nxt;

  // Full is judged on the pre-edge count, so a pop at the same edge does not
  // free a slot for the push offered at that edge.
  assign in_ready = !reset && (count < CW'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign head     = mem[rptr];
  assign busy     = (state != IDLE) || (count != '0);

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    wr_nxt    = wr;
    dcx_nxt   = dcx;
    d_nxt     = D;
    done_nxt  = 1'b0;
    pop       = 1'b0;

    case (state)
      IDLE: begin
        wr_nxt = 1'b1;
        if (count != '0) begin
          pop       = 1'b1;
          dcx_nxt   = head[8];
          d_nxt     = head[7:0];
          state_nxt = SETUP;
          phase_nxt = '0;
        end
      end
      SETUP: begin
        wr_nxt    = 1'b0;
        state_nxt = WR_LOW;
        phase_nxt = PW'(WR_LOW_CYC - 1);
      end
      WR_LOW: begin
        if (phase == '0) begin
          wr_nxt    = 1'b1;
          state_nxt = WR_HIGH;
          phase_nxt = PW'(WR_HIGH_CYC - 1);
        end else begin
          phase_nxt = phase - PW'(1);
        end
      end
      WR_HIGH: begin
        if (phase == '0) begin
          done_nxt  = 1'b1;
          phase_nxt = '0;
          // Chain straight into the next byte so a full queue streams with
          // no idle cycle between strobes.
          if (count != '0) begin
            pop       = 1'b1;
            dcx_nxt   = head[8];
            d_nxt     = head[7:0];
            state_nxt = SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          phase_nxt = phase - PW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = '0;
        wr_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge hwclk) begin
    if (reset) begin
      state      <= IDLE;
      phase      <= '0;
      wr         <= 1'b1;
      dcx        <= 1'b0;
      D          <= 8'h00;
      done_pulse <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      wr         <= wr_nxt;
      dcx        <= dcx_nxt;
      D          <= d_nxt;
      done_pulse <= done_nxt;
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; push is already blocked while reset is high.
  always_ff @(posedge hwclk) begin
    if (push) mem[wptr] <= {in_dcx, in_byte};
  end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// tb/tb_lcd_bus_writer.sv - self-checking bench for lcd_bus_writer

module tb_lcd_bus_writer;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic       reset;
  logic       in_valid, in_dcx;
  logic [7:0] in_byte;
  logic       in_ready, busy, done_pulse, dcx, wr;
  logic [7:0] D;

  logic       sw_valid, sw_dcx;
  logic [7:0] sw_byte;
  logic       b_ready, b_busy, b_done, b_dcx, b_wr;
  logic [7:0] b_d;
  logic       c_ready, c_busy, c_done, c_dcx, c_wr;
  logic [7:0] c_d;

  lcd_bus_writer dut (
    .hwclk(tb_clk), .reset(reset), .in_valid(in_valid), .in_dcx(in_dcx),
    .in_byte(in_byte), .in_ready(in_ready), .busy(busy),
    .done_pulse(done_pulse), .dcx(dcx), .wr(wr), .D(D)
  );

  lcd_bus_writer #(.WR_LOW_CYC(1), .WR_HIGH_CYC(1), .FIFO_DEPTH(4)) dut_b (
    .hwclk(tb_clk), .reset(reset), .in_valid(sw_valid), .in_dcx(sw_dcx),
    .in_byte(sw_byte), .in_ready(b_ready), .busy(b_busy),
    .done_pulse(b_done), .dcx(b_dcx), .wr(b_wr), .D(b_d)
  );

  lcd_bus_writer #(.WR_LOW_CYC(4), .WR_HIGH_CYC(3), .FIFO_DEPTH(4)) dut_c (
    .hwclk(tb_clk), .reset(reset), .in_valid(sw_valid), .in_dcx(sw_dcx),
    .in_byte(sw_byte), .in_ready(c_ready), .busy(c_busy),
    .done_pulse(c_done), .dcx(c_dcx), .wr(c_wr), .D(c_d)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_periods(input string tag, input int q[$], input int first,
                               input int n, input int per);
    for (int i = first + 1; i < first + n; i++) begin
      if (i < q.size()) check(tag, q[i] - q[i-1], per);
    end
  endtask

  // Scoreboard: items accepted at an edge are queued, popped at each wr fall.
  logic [8:0] sbq[$];
  logic       rst_edge = 1'b0;

  always @(posedge tb_clk) begin
    cyc      <= cyc + 1;
    rst_edge <= reset;
    if (reset) sbq.delete();
    else if (in_valid && in_ready) sbq.push_back({in_dcx, in_byte});
  end

  int         a_low = 0, a_done = 0;
  bit         a_prev = 1'b1, a_inhigh = 1'b0;
  logic [8:0] a_held = '0;
  logic [8:0] exp_item;
  int         a_falls[$];

  always @(negedge tb_clk) begin
    if (rst_edge) a_inhigh = 1'b0;
    if (wr === 1'b0) begin
      if (a_prev) begin
        check("a_sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          exp_item = sbq.pop_front();
          check("a_fall_item", {dcx, D}, exp_item);
        end
        a_held = {dcx, D};
        a_low  = 1;
        a_falls.push_back(cyc);
      end else begin
        check("a_low_hold", {dcx, D}, a_held);
        a_low++;
      end
    end else if (wr === 1'b1) begin
      if (!a_prev && !rst_edge) begin
        check("a_low_width", a_low, 2);
        a_inhigh = 1'b1;
      end else if (a_inhigh) begin
        if (done_pulse === 1'b1) a_inhigh = 1'b0;
        else check("a_high_hold", {dcx, D}, a_held);
      end
    end
    if (done_pulse === 1'b1) a_done++;
    a_prev = (wr !== 1'b0);
  end

  logic [8:0] sw_exp [3];
  int b_low = 0, b_done_cnt = 0, b_idx = 0;
  int c_low = 0, c_done_cnt = 0, c_idx = 0;
  bit b_prev = 1'b1, c_prev = 1'b1;
  int b_falls[$], c_falls[$];

  always @(negedge tb_clk) begin
    if (b_wr === 1'b0) begin
      if (b_prev) begin
        b_falls.push_back(cyc);
        check("b_item", {b_dcx, b_d}, sw_exp[b_idx % 3]);
        b_idx++;
        b_low = 1;
      end else b_low++;
    end else if (b_wr === 1'b1 && !b_prev && !rst_edge) begin
      check("b_low_width", b_low, 1);
    end
    if (b_done === 1'b1) b_done_cnt++;
    b_prev = (b_wr !== 1'b0);

    if (c_wr === 1'b0) begin
      if (c_prev) begin
        c_falls.push_back(cyc);
        check("c_item", {c_dcx, c_d}, sw_exp[c_idx % 3]);
        c_idx++;
        c_low = 1;
      end else c_low++;
    end else if (c_wr === 1'b1 && !c_prev && !rst_edge) begin
      check("c_low_width", c_low, 4);
    end
    if (c_done === 1'b1) c_done_cnt++;
    c_prev = (c_wr !== 1'b0);
  end

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((busy !== 1'b0 || b_busy !== 1'b0 || c_busy !== 1'b0) && k < budget) begin
      @(negedge tb_clk);
      k++;
    end
    check("drain_in_time", k < budget, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts, waits, done0, nfall0;
    bit seen_block, reassert_checked;

    sw_exp[0] = {1'b1, 8'h40};
    sw_exp[1] = {1'b0, 8'h41};
    sw_exp[2] = {1'b1, 8'h42};
    reset = 1'b1; in_valid = 1'b0; in_dcx = 1'b0; in_byte = 8'h00;
    sw_valid = 1'b0; sw_dcx = 1'b0; sw_byte = 8'h00;

    // Reset state
    @(negedge tb_clk);
    in_valid = 1'b1;
    check("rst_ready_low", in_ready, 0);
    @(negedge tb_clk);
    in_valid = 1'b0;
    check("rst_wr", wr, 1);
    check("rst_dcx", dcx, 0);
    check("rst_d", D, 8'h00);
    check("rst_done", done_pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_sb_empty", sbq.size(), 0);
    reset = 1'b0;
    #1 check("ready_after_rst", in_ready, 1);

    // Test 1: single command byte, push at E0
    in_valid = 1'b1; in_dcx = 1'b0; in_byte = 8'h2C;
    @(negedge tb_clk);
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("t1_wr", wr, (k == 2 || k == 3) ? 0 : 1);
      check("t1_done", done_pulse, k == 6);
      check("t1_busy", busy, k < 6);
      if (k >= 1) begin
        check("t1_d", D, 8'h2C);
        check("t1_dcx", dcx, 0);
      end
      @(negedge tb_clk);
    end

    // Tests 2/3: burst of 6 data bytes into a 4-deep FIFO. From idle the
    // first item leaves the FIFO one edge after it arrives, so the fifth
    // accept is the one that fills it.
    done0 = a_done; nfall0 = a_falls.size();
    accepts = 0; seen_block = 0; reassert_checked = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_dcx = 1'b1; in_byte = 8'h10 + 8'(i);
      waits = 0;
      while (in_ready !== 1'b1 && waits < 50) begin
        if (!seen_block) begin
          seen_block = 1;
          check("t2_accepts_before_full", accepts, 5);
        end
        @(negedge tb_clk);
        waits++;
        if (in_ready === 1'b1 && !reassert_checked) begin
          reassert_checked = 1;
          check("t3_reassert_on_pop", done_pulse, 1);
        end
      end
      check("t2_ready_in_time", waits < 50, 1);
      @(negedge tb_clk);
      accepts++;
      if (i == 5) check("t3_full_again", in_ready, 0);
    end
    in_valid = 1'b0;
    check("t2_saw_block", seen_block, 1);
    wait_idle(200);
    #1;
    check("t2_done_count", a_done - done0, 6);
    check("t2_fall_count", a_falls.size() - nfall0, 6);
    check_periods("t2_period", a_falls, nfall0, 6, 5);
    check("t2_sb_empty", sbq.size(), 0);

    // Test 4: reset while wr is low with two items queued
    @(negedge tb_clk);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_dcx = 1'b1; in_byte = 8'h30 + 8'(i);
      @(negedge tb_clk);
    end
    in_valid = 1'b0;
    check("t4_wr_low", wr, 0);
    check("t4_busy_before", busy, 1);
    done0 = a_done;
    reset = 1'b1;
    #1 check("t4_ready_in_reset", in_ready, 0);
    @(negedge tb_clk);
    reset = 1'b0;
    check("t4_wr", wr, 1);
    check("t4_d", D, 8'h00);
    check("t4_dcx", dcx, 0);
    check("t4_busy", busy, 0);
    check("t4_done", done_pulse, 0);
    for (int k = 0; k < 15; k++) begin
      @(negedge tb_clk);
      check("t4_no_strobe", wr, 1);
      check("t4_no_done", done_pulse, 0);
    end
    check("t4_done_count", a_done - done0, 0);
    check("t4_sb_flushed", sbq.size(), 0);

    // Test 5: parameter sweep instances, three back-to-back items each
    for (int i = 0; i < 3; i++) begin
      sw_valid = 1'b1; sw_dcx = sw_exp[i][8]; sw_byte = sw_exp[i][7:0];
      check("t5_b_ready", b_ready, 1);
      check("t5_c_ready", c_ready, 1);
      @(negedge tb_clk);
    end
    sw_valid = 1'b0;
    wait_idle(200);
    #1;
    check("t5_b_falls", b_falls.size(), 3);
    check("t5_c_falls", c_falls.size(), 3);
    check_periods("t5_b_period", b_falls, 0, 3, 3);
    check_periods("t5_c_period", c_falls, 0, 3, 8);
    check("t5_b_done", b_done_cnt, 3);
    check("t5_c_done", c_done_cnt, 3);

    // Test 6: idle hold after last byte
    @(negedge tb_clk);
    in_valid = 1'b1; in_dcx = 1'b1; in_byte = 8'hA5;
    @(negedge tb_clk);
    in_valid = 1'b0;
    wait_idle(100);
    for (int k = 0; k < 20; k++) begin
      @(negedge tb_clk);
      check("t6_d", D, 8'hA5);
      check("t6_dcx", dcx, 1);
      check("t6_wr", wr, 1);
      check("t6_busy", busy, 0);
      check("t6_ready", in_ready, 1);
    end
    check("t6_sb_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
